// File: rtl/cache_sa_wb.sv
// Set-associative write-back / write-allocate cache with LRU replacement and a miss FSM.
// Optional hit/miss counters are compiled in when CACHE_STATS_EN is defined.
module cache_sa_wb #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_BYTES = 16,
  parameter int NUM_SETS    = 4,
  parameter int WAYS        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req_valid,
  output logic                     cpu_req_ready,
  input  logic                     cpu_req_we,
  input  logic [ADDR_W-1:0]        cpu_req_addr,
  input  logic [7:0]               cpu_req_wdata,
  output logic                     cpu_resp_valid,
  output logic [7:0]               cpu_resp_rdata,
  output logic                     cpu_resp_hit,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [BLOCK_BYTES*8-1:0] mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [BLOCK_BYTES*8-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int BLK_W = BLOCK_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   req_addr;
  logic                req_we;
  logic [7:0]          req_wdata;
  logic                miss_flag;
  logic                victim_q;

  logic [NUM_SETS-1:0] valid_q [WAYS];
  logic [NUM_SETS-1:0] dirty_q [WAYS];
  logic [TAG_W-1:0]    tag_q   [WAYS][NUM_SETS];
  logic [BLK_W-1:0]    data_q  [WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;

  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;

  logic                hit;
  logic                hit_way;
  logic                victim;
  logic                victim_found;
  logic                victim_dirty;
  logic [BLK_W-1:0]    hit_block;
  logic [7:0]          hit_byte;

  assign req_off = req_addr[OFF_W-1:0];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Invalid ways are filled before anything is evicted; way 0 is preferred.
  always_comb begin
    victim       = (WAYS == 2) ? lru_q[req_idx] : 1'b0;
    victim_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[w][req_idx]) begin
        victim       = 1'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign victim_dirty = valid_q[victim][req_idx] && dirty_q[victim][req_idx];
  assign hit_block    = data_q[hit_way][req_idx];
  assign hit_byte     = hit_block[{req_off, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cpu_req_valid) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit)               state_nxt = IDLE;
        else if (victim_dirty) state_nxt = WB_REQ;
        else                   state_nxt = FILL_REQ;
      end
      WB_REQ:    if (mem_req_ready)  state_nxt = FILL_REQ;
      FILL_REQ:  if (mem_req_ready)  state_nxt = FILL_WAIT;
      FILL_WAIT: if (mem_resp_valid) state_nxt = LOOKUP;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so an aborted request is never seen as a handshake.
  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    cpu_resp_hit   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    if (!rst) begin
      case (state)
        IDLE: cpu_req_ready = 1'b1;
        LOOKUP: begin
          if (hit) begin
            cpu_resp_valid = 1'b1;
            cpu_resp_hit   = !miss_flag;
            if (!req_we) cpu_resp_rdata = hit_byte;
          end
        end
        WB_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
          mem_req_wdata = data_q[victim_q][req_idx];
        end
        FILL_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      lru_q     <= '0;
      miss_flag <= 1'b0;
      victim_q  <= 1'b0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
`ifdef CACHE_STATS_EN
      stat_hits   <= '0;
      stat_misses <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_addr  <= cpu_req_addr;
            req_we    <= cpu_req_we;
            req_wdata <= cpu_req_wdata;
            miss_flag <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we) begin
              data_q[hit_way][req_idx][{req_off, 3'b000} +: 8] <= req_wdata;
              dirty_q[hit_way][req_idx] <= 1'b1;
            end
            if (WAYS == 2) lru_q[req_idx] <= ~hit_way;
`ifdef CACHE_STATS_EN
            if (!miss_flag) stat_hits <= stat_hits + 32'd1;
`endif
          end else begin
            miss_flag <= 1'b1;
            victim_q  <= victim;
`ifdef CACHE_STATS_EN
            if (!miss_flag) stat_misses <= stat_misses + 32'd1;
`endif
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            data_q[victim_q][req_idx]  <= mem_resp_rdata;
            tag_q[victim_q][req_idx]   <= req_tag;
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sa_wb.sv
// Bench for cache_sa_wb: directed scenarios plus random traffic checked against an LRU-list
// model of the cache and a byte-array model of memory.
module tb_cache_sa_wb;

  localparam int ADDR_W = 10;
  localparam int BB     = 16;
  localparam int WAYS   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req_valid = 1'b0;
  logic              cpu_req_ready;
  logic              cpu_req_we = 1'b0;
  logic [ADDR_W-1:0] cpu_req_addr = '0;
  logic [7:0]        cpu_req_wdata = '0;
  logic              cpu_resp_valid;
  logic [7:0]        cpu_resp_rdata;
  logic              cpu_resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [BB*8-1:0]   mem_req_wdata;
  logic              mem_resp_valid = 1'b0;
  logic [BB*8-1:0]   mem_resp_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;
`endif

  cache_sa_wb #(.ADDR_W(ADDR_W), .BLOCK_BYTES(BB), .NUM_SETS(4), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] backmem [1024];
  logic [7:0] truemem [1024];
  int         rt [4][2];
  int         rn [4];
  bit         dirty_blk [64];
  int         stall_left = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] true_blk(input int base);
    logic [127:0] r;
    for (int o = 0; o < BB; o++) r[o*8 +: 8] = truemem[base + o];
    return r;
  endfunction

  function automatic logic [127:0] back_blk(input int base);
    logic [127:0] r;
    for (int o = 0; o < BB; o++) r[o*8 +: 8] = backmem[base + o];
    return r;
  endfunction

  function automatic logic [9:0] rand_addr();
    logic [3:0] t;
    logic [1:0] s;
    logic [3:0] o;
    t = 4'($urandom_range(0, 4));
    s = 2'($urandom_range(0, 3));
    o = 4'($urandom_range(0, 15));
    return {t, s, o};
  endfunction

  // Reset loses any dirty data held only in the cache.
  task automatic model_reset();
    for (int i = 0; i < 1024; i++) truemem[i] = backmem[i];
    for (int i = 0; i < 4; i++) rn[i] = 0;
    for (int i = 0; i < 64; i++) dirty_blk[i] = 1'b0;
  endtask

  task automatic access(input logic we, input logic [9:0] a, input logic [7:0] wd);
    int s, tg, hp, vb, fdelay;
    bit ehit, ewb, swb, sfill, done, fpend, stalled;
    logic [9:0]   wb_addr, fill_addr, h_addr;
    logic [127:0] wb_data, fill_data, h_data;
    logic [7:0]   erd;
    logic         h_we;
    s = int'(a[5:4]);
    tg = int'(a[9:6]);
    hp = -1;
    for (int i = 0; i < rn[s]; i++) if (rt[s][i] == tg) hp = i;
    ehit = (hp >= 0);
    ewb = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    fill_addr = {a[9:4], 4'h0};
    fill_data = '0;
    erd = we ? 8'h00 : truemem[a];
    if (ehit) begin
      if (hp == 1) begin
        rt[s][1] = rt[s][0];
        rt[s][0] = tg;
      end
    end else begin
      if (rn[s] == WAYS) begin
        vb = rt[s][WAYS-1] * 4 + s;
        if (dirty_blk[vb]) begin
          ewb = 1'b1;
          wb_addr = 10'(vb * 16);
          wb_data = true_blk(vb * 16);
          for (int o = 0; o < BB; o++) backmem[vb*16 + o] = truemem[vb*16 + o];
          dirty_blk[vb] = 1'b0;
        end
      end else begin
        rn[s]++;
      end
      rt[s][1] = rt[s][0];
      rt[s][0] = tg;
      fill_data = back_blk(int'(fill_addr));
    end
    if (we) begin
      truemem[a] = wd;
      dirty_blk[a[9:4]] = 1'b1;
    end

    for (int i = 0; i < 50 && !cpu_req_ready; i++) @(negedge clk);
    chk("req_ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'($urandom);
    cpu_req_addr  = 10'($urandom);
    cpu_req_wdata = 8'($urandom);
    swb = 0; sfill = 0; done = 0; fpend = 0; stalled = 0; fdelay = 0;
    h_we = 1'b0; h_addr = '0; h_data = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      mem_resp_valid = 1'b0;
      if (cpu_resp_valid) begin
        chk("resp_rdata", cpu_resp_rdata, erd);
        chk("resp_hit", cpu_resp_hit, ehit);
        if (ehit) chk("hit_latency", cyc, 0);
        chk("wb_done", swb, ewb);
        chk("fill_done", sfill, !ehit);
        done = 1'b1;
      end else begin
        chk("busy_not_ready", cpu_req_ready, 0);
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          if (stalled) begin
            chk("stall_we", mem_req_we, h_we);
            chk("stall_addr", mem_req_addr, h_addr);
            chk("stall_wdata", mem_req_wdata, h_data);
          end else if (mem_req_we) begin
            chk("wb_expected", ewb && !swb, 1);
            chk("wb_addr", mem_req_addr, wb_addr);
            chk("wb_wdata", mem_req_wdata, wb_data);
          end else begin
            chk("fill_expected", !ehit && !sfill, 1);
            chk("fill_order", swb, ewb);
            chk("fill_addr", mem_req_addr, fill_addr);
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            mem_req_ready = ($urandom_range(0, 3) != 0);
          end
          stalled = !mem_req_ready;
          h_we = mem_req_we;
          h_addr = mem_req_addr;
          h_data = mem_req_wdata;
          if (mem_req_ready) begin
            if (mem_req_we) swb = 1'b1;
            else begin
              sfill = 1'b1;
              fpend = 1'b1;
              fdelay = $urandom_range(0, 3);
            end
          end
        end else begin
          stalled = 1'b0;
          if (fpend) begin
            if (fdelay == 0) begin
              mem_resp_valid = 1'b1;
              mem_resp_rdata = fill_data;
              fpend = 1'b0;
            end else begin
              fdelay--;
            end
          end
        end
      end
      if (!done) @(negedge clk);
    end
    chk("resp_seen", done, 1);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    bit got_fill;
    for (int i = 0; i < 1024; i++) backmem[i] = 8'($urandom);
    backmem[0] = 8'hA5;
    model_reset();

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", cpu_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_resp_valid", cpu_resp_valid, 0);
`ifdef CACHE_STATS_EN
    chk("rst_stat_hits", stat_hits, 0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_req_ready", cpu_req_ready, 1);

    access(1'b0, 10'h000, 8'h00);
    access(1'b0, 10'h000, 8'h00);
    access(1'b1, 10'h003, 8'h5C);
    access(1'b0, 10'h003, 8'h00);
    access(1'b0, 10'h040, 8'h00);
    access(1'b0, 10'h080, 8'h00);
    access(1'b0, 10'h040, 8'h00);
`ifdef CACHE_STATS_EN
    chk("stat_hits", stat_hits, 4);
    chk("stat_misses", stat_misses, 3);
`endif

    access(1'b1, 10'h085, 8'h3E);
    access(1'b0, 10'h040, 8'h00);
    stall_left = 5;
    access(1'b0, 10'h0C0, 8'h00);
    chk("stall_consumed", stall_left, 0);

    repeat (300) begin
      if ($urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {4{32'($urandom)}};
        @(negedge clk);
      end
      access(1'($urandom), rand_addr(), 8'($urandom));
    end

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
`ifdef CACHE_STATS_EN
    chk("rst_stat_hits2", stat_hits, 0);
    chk("rst_stat_misses2", stat_misses, 0);
`endif
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 10'h3C0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    got_fill = 1'b0;
    for (int i = 0; i < 20 && !got_fill; i++) begin
      if (mem_req_valid && !mem_req_we) begin
        mem_req_ready = 1'b1;
        got_fill = 1'b1;
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    chk("abort_fill_req", got_fill, 1);
    rst = 1'b1;
    #1;
    chk("abort_no_resp", cpu_resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_mem_valid", mem_req_valid, 0);
    chk("abort_resp_valid", cpu_resp_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = {4{32'hDEADBEEF}};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stale_fill_ignored", cpu_resp_valid, 0);
    chk("stale_fill_idle", cpu_req_ready, 1);
    access(1'b0, 10'h000, 8'h00);
    access(1'b0, 10'h3C0, 8'h00);

    repeat (40) access(1'($urandom), rand_addr(), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
